// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave core.
package i2c_slave_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h10;

  // Values seen on SDA during the ACK bit; a released line reads as NACK.
  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Pad and host-port bundle of the I2C slave core.
interface i2c_slave_if #(
  parameter int PTR_W = 3
);
  logic             scl_pad_i;
  logic             scl_pad_o;
  logic             scl_padoen_o;
  logic             sda_pad_i;
  logic             sda_pad_o;
  logic             sda_padoen_o;
  logic [PTR_W-1:0] reg_adr_i;
  logic [7:0]       reg_dat_i;
  logic             reg_we_i;
  logic [7:0]       reg_dat_o;
  logic             wr_stb_o;
  logic [PTR_W-1:0] wr_adr_o;
  logic             busy_o;

  modport slave (
    input  scl_pad_i, sda_pad_i, reg_adr_i, reg_dat_i, reg_we_i,
    output scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
           reg_dat_o, wr_stb_o, wr_adr_o, busy_o
  );

  modport master (
    output scl_pad_i, sda_pad_i, reg_adr_i, reg_dat_i, reg_we_i,
    input  scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
           reg_dat_o, wr_stb_o, wr_adr_o, busy_o
  );

endinterface

// File: rtl/i2c_slave_sync.sv
// Two-flop synchronizer plus history flop for one bus line; yields level and edges.
module i2c_slave_sync (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       hist_q;

  // Idle I2C lines are high, so everything resets to 1 to avoid a fake edge.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], d};
      hist_q <= sync_q[1];
    end
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~hist_q;
  assign fall = ~sync_q[1] & hist_q;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave with a byte-addressed register file shared with a local host port.
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int         PTR_W      = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  i2c_slave_if.slave bus
);

  localparam int DEPTH = 1 << PTR_W;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] pad_in, lvl, rise, fall;

  assign pad_in = {bus.sda_pad_i, bus.scl_pad_i};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    i2c_slave_sync u_sync (
      .gclk  (wb_clk_i),
      .grst_n(arst_i),
      .d     (pad_in[i]),
      .lvl   (lvl[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  logic scl_rise, scl_fall, sda_lvl, start_c, stop_c;
  assign scl_rise = rise[0];
  assign scl_fall = fall[0];
  assign sda_lvl  = lvl[1];
  assign start_c  = fall[1] & lvl[0];
  assign stop_c   = rise[1] & lvl[0];

  state_t                   state;
  logic [2:0]               bit_cnt;
  logic [7:0]               sreg;
  logic [PTR_W-1:0]         ptr;
  logic                     rw;
  logic                     phase;     // ACK states: ACK driven / master ACK seen
  logic                     sda_oe_n;
  logic                     wr_stb;
  logic [PTR_W-1:0]         wr_adr;
  logic                     busy;
  logic [7:0]               reg_dat;
  logic [DEPTH-1:0][7:0]    mem;

  logic [7:0] byte_in;
  logic       last_bit;
  logic       i2c_we;

  assign byte_in  = {sreg[6:0], sda_lvl};
  assign last_bit = (bit_cnt == 3'd7);
  // START/STOP take priority, so a commit is suppressed in that cycle.
  assign i2c_we   = (state == ST_WDATA) & scl_rise & last_bit & ~start_c & ~stop_c;

  // Protocol FSM: bus conditions first, then per-state bit handling.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      sreg     <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      phase    <= 1'b0;
      sda_oe_n <= 1'b1;
      wr_stb   <= 1'b0;
      wr_adr   <= '0;
      busy     <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (start_c) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        sda_oe_n <= 1'b1;
      end else if (stop_c) begin
        state    <= ST_IDLE;
        phase    <= 1'b0;
        sda_oe_n <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            sreg    <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw    <= byte_in[0];
                busy  <= 1'b1;
                state <= ST_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            sreg    <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ptr   <= byte_in[PTR_W-1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            sreg    <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              wr_stb <= 1'b1;
              wr_adr <= ptr;
              ptr    <= ptr + 1'b1;
              state  <= ST_WDATA_ACK;
            end
          end
          // First fall: pull SDA low. Second fall: ACK clock done, move on.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!phase) begin
              phase    <= 1'b1;
              sda_oe_n <= ACK_BIT;
            end else begin
              phase    <= 1'b0;
              sda_oe_n <= NACK_BIT;
              if (state == ST_ADDR_ACK && rw) begin
                sreg     <= mem[ptr];
                sda_oe_n <= mem[ptr][7];
                state    <= ST_RDATA;
              end else if (state == ST_ADDR_ACK) begin
                state <= ST_PTR;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          // Present the next bit on each fall; the 8th fall hands SDA back.
          ST_RDATA: if (scl_fall) begin
            if (last_bit) begin
              sda_oe_n <= NACK_BIT;
              bit_cnt  <= '0;
              state    <= ST_RDATA_ACK;
            end else begin
              sreg     <= {sreg[6:0], sreg[7]};
              sda_oe_n <= sreg[6];
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
          // Sample master ACK on rise; next byte goes out on the following fall.
          ST_RDATA_ACK: begin
            if (scl_rise && !phase) begin
              ptr <= ptr + 1'b1;
              if (sda_lvl == ACK_BIT) phase <= 1'b1;
              else                    state <= ST_WAIT_STOP;
            end else if (scl_fall && phase) begin
              phase    <= 1'b0;
              sreg     <= mem[ptr];
              sda_oe_n <= mem[ptr][7];
              state    <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file: an I2C commit overrides a host write to the same index.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      mem <= '0;
    end else begin
      if (bus.reg_we_i) mem[bus.reg_adr_i] <= bus.reg_dat_i;
      if (i2c_we)       mem[ptr]           <= byte_in;
    end
  end

  // Registered host read port.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) reg_dat <= '0;
    else         reg_dat <= mem[bus.reg_adr_i];
  end

  assign bus.scl_pad_o    = 1'b0;
  assign bus.scl_padoen_o = 1'b1;
  assign bus.sda_pad_o    = 1'b0;
  assign bus.sda_padoen_o = sda_oe_n;
  assign bus.reg_dat_o    = reg_dat;
  assign bus.wr_stb_o     = wr_stb;
  assign bus.wr_adr_o     = wr_adr;
  assign bus.busy_o       = busy;

endmodule
